// File: rtl/sia_pkg.sv
// sia_pkg: shared receiver state encoding and default widths for the SIA receive path
package sia_pkg;
    localparam int SHIFT_REG_WIDTH_D = 16;
    localparam int BITS_WIDTH_D      = 5;
    localparam int BAUD_RATE_WIDTH_D = 32;
    localparam int DEPTH_BITS_D      = 4;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        PUSH   = 2'd2
    } state_t;
endpackage

// File: rtl/sia_rxq_fifo.sv
// sia_rxq_fifo: queue FIFO with registered head output loaded on an output-enable strobe
module sia_rxq_fifo
    import sia_pkg::*;
#(
    parameter int DEPTH_BITS = DEPTH_BITS_D,
    parameter int DATA_BITS  = SHIFT_REG_WIDTH_D
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 push_i,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 oe_i,
    output logic [DATA_BITS-1:0] dat_o,
    output logic                 not_empty_o,
    output logic                 full_o
);
    logic [DATA_BITS-1:0]  mem [2**DEPTH_BITS];
    logic [DEPTH_BITS:0]   wp, rp;
    logic                  wr, rd;
    assign not_empty_o = wp != rp;
    assign full_o      = (wp[DEPTH_BITS] != rp[DEPTH_BITS]) && (wp[DEPTH_BITS-1:0] == rp[DEPTH_BITS-1:0]);
    assign rd          = oe_i & not_empty_o;
    assign wr          = push_i & (~full_o | rd);
    // storage write; a read of the same slot in the same cycle still sees the old head
    always_ff @(posedge clk_i) begin
        if (wr) mem[wp[DEPTH_BITS-1:0]] <= data_i;
    end
    // pointer advance and head register load
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wp    <= '0;
            rp    <= '0;
            dat_o <= '0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (rd) begin
                rp    <= rp + 1'b1;
                dat_o <= mem[rp[DEPTH_BITS-1:0]];
            end
        end
    end
endmodule

// File: rtl/sia_rxq.sv
// sia_rxq: asynchronous serial receiver that queues left-aligned frames for a processor
module sia_rxq
    import sia_pkg::*;
#(
    parameter int SHIFT_REG_WIDTH = SHIFT_REG_WIDTH_D,
    parameter int BITS_WIDTH      = BITS_WIDTH_D,
    parameter int BAUD_RATE_WIDTH = BAUD_RATE_WIDTH_D,
    parameter int DEPTH_BITS      = DEPTH_BITS_D
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       rxd_i,
    input  logic [BITS_WIDTH-1:0]      bits_i,
    input  logic [BAUD_RATE_WIDTH-1:0] baud_i,
    input  logic                       pop_i,
    input  logic                       clr_ovr_i,
    output logic [SHIFT_REG_WIDTH-1:0] dat_o,
    output logic                       not_empty_o,
    output logic                       full_o,
    output logic                       overrun_o,
    output logic                       idle_o
);
    state_t                       state;
    logic [1:0]                   sync;
    logic                         rxs, fall, first, push, pop;
    logic [BITS_WIDTH-1:0]        nbits, bitcnt;
    logic [BAUD_RATE_WIDTH-1:0]   period, per, cnt;
    logic [SHIFT_REG_WIDTH-1:0]   sr;
    assign rxs    = sync[1];
    assign fall   = sync[1] & ~sync[0];
    assign nbits  = (bits_i > BITS_WIDTH'(SHIFT_REG_WIDTH)) ? BITS_WIDTH'(SHIFT_REG_WIDTH) : bits_i;
    assign period = (baud_i == '0) ? BAUD_RATE_WIDTH'(1) : baud_i;
    assign push   = state == PUSH;
    assign pop    = pop_i & not_empty_o;
    assign idle_o = state == IDLE;
    // two-flop synchronizer on the asynchronous line, idling high
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) sync <= 2'b11;
        else           sync <= {sync[0], rxd_i};
    end
    // receiver FSM: start detect, mid-bit sampling into the shift register, one-cycle push
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state  <= IDLE;
            cnt    <= '0;
            per    <= '0;
            bitcnt <= '0;
            first  <= 1'b0;
            sr     <= '0;
        end else begin
            case (state)
                IDLE: if (nbits != '0 && fall) begin
                    cnt    <= period >> 1;
                    per    <= period;
                    bitcnt <= nbits;
                    first  <= 1'b1;
                    state  <= SAMPLE;
                end
                SAMPLE: if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else if (first && rxs) begin
                    state <= IDLE;
                end else begin
                    sr     <= {rxs, sr[SHIFT_REG_WIDTH-1:1]};
                    bitcnt <= bitcnt - 1'b1;
                    cnt    <= per - 1'b1;
                    first  <= 1'b0;
                    if (bitcnt == BITS_WIDTH'(1)) state <= PUSH;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // sticky overrun; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)                   overrun_o <= 1'b0;
        else if (push & full_o & ~pop)   overrun_o <= 1'b1;
        else if (clr_ovr_i)              overrun_o <= 1'b0;
    end
    sia_rxq_fifo #(
        .DEPTH_BITS (DEPTH_BITS),
        .DATA_BITS  (SHIFT_REG_WIDTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .push_i      (push),
        .data_i      (sr),
        .oe_i        (pop),
        .dat_o       (dat_o),
        .not_empty_o (not_empty_o),
        .full_o      (full_o)
    );
endmodule

// File: tb/tb_sia_rxq.sv
// tb_sia_rxq: table-driven and scoreboard checks of the SIA receive queue
module tb_sia_rxq;
    import sia_pkg::*;
    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        rxd_i = 1'b1;
    logic [4:0]  bits_i = 5'd10;
    logic [31:0] baud_i = 32'd4;
    logic        pop_i = 1'b0;
    logic        clr_ovr_i = 1'b0;
    logic [15:0] dat_o;
    logic        not_empty_o, full_o, overrun_o, idle_o;

    typedef struct {
        logic [4:0]  bits;
        logic [31:0] baud;
        int          nsend;
        logic [15:0] frame;
        logic [15:0] exp;
    } vec_t;
    typedef struct {
        logic [15:0] exp;
        logic [15:0] mask;
    } sb_t;

    sb_t sbq[$];
    vec_t vecs[7];
    int n_checks = 0;
    int n_fail = 0;

    sia_rxq dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .rxd_i       (rxd_i),
        .bits_i      (bits_i),
        .baud_i      (baud_i),
        .pop_i       (pop_i),
        .clr_ovr_i   (clr_ovr_i),
        .dat_o       (dat_o),
        .not_empty_o (not_empty_o),
        .full_o      (full_o),
        .overrun_o   (overrun_o),
        .idle_o      (idle_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] top_mask(input int n);
        logic [15:0] m;
        m = 16'hFFFF;
        return (n >= 16) ? m : ~(m >> n);
    endfunction

    task automatic send_bits(input logic [15:0] frame, input int n, input int p);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            rxd_i = frame[i];
            repeat (p - 1) @(negedge clk_i);
        end
    endtask

    task automatic idle_gap(input int c);
        @(negedge clk_i);
        rxd_i = 1'b1;
        repeat (c) @(negedge clk_i);
    endtask

    task automatic sb_push(input logic [15:0] frame, input int n);
        sb_t e;
        e.mask = top_mask(n);
        e.exp  = 16'(frame << (16 - n)) & e.mask;
        sbq.push_back(e);
    endtask

    task automatic sb_compare(input string name);
        sb_t e;
        if (sbq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got %0h expected nothing queued", name, dat_o);
        end else begin
            e = sbq.pop_front();
            check(name, dat_o & e.mask, e.exp);
        end
    endtask

    task automatic do_pop(input string name);
        @(negedge clk_i);
        pop_i = 1'b1;
        @(negedge clk_i);
        pop_i = 1'b0;
        sb_compare(name);
    endtask

    // fills the model and DUT with frames tagged by base+i, no popping
    task automatic fill(input int count, input int base);
        logic [15:0] f;
        for (int i = 0; i < count; i++) begin
            f = 16'h200 | 16'((base + i) << 1);
            send_bits(f, 10, 4);
            idle_gap(16);
            if (sbq.size() < 16) sb_push(f, 10);
        end
    endtask

    initial begin
        logic        idle_ok;
        logic        seen;
        logic [15:0] last_exp, last_mask;
        vecs[0] = '{5'd10, 32'd4, 10, 16'h02AA, 16'hAA80};
        vecs[1] = '{5'd8,  32'd3, 8,  16'h00B6, 16'hB600};
        vecs[2] = '{5'd16, 32'd5, 16, 16'hC35A, 16'hC35A};
        vecs[3] = '{5'd12, 32'd0, 12, 16'h09F4, 16'h9F40};
        vecs[4] = '{5'd9,  32'd2, 9,  16'h01E6, 16'hF300};
        vecs[5] = '{5'd20, 32'd6, 16, 16'h1234, 16'h1234};
        vecs[6] = '{5'd4,  32'd7, 4,  16'h0006, 16'h6000};

        repeat (3) @(negedge clk_i);
        check("rst_dat", dat_o, 0);
        check("rst_not_empty", not_empty_o, 0);
        check("rst_full", full_o, 0);
        check("rst_overrun", overrun_o, 0);
        check("rst_idle", idle_o, 1);
        reset_ni = 1'b1;
        idle_gap(4);

        last_exp = '0;
        last_mask = '0;
        foreach (vecs[k]) begin
            int pp;
            sb_t e;
            pp = (vecs[k].baud == 0) ? 1 : int'(vecs[k].baud);
            bits_i = vecs[k].bits;
            baud_i = vecs[k].baud;
            send_bits(vecs[k].frame, vecs[k].nsend, pp);
            e.exp = vecs[k].exp;
            e.mask = top_mask(vecs[k].nsend);
            sbq.push_back(e);
            last_exp = e.exp;
            last_mask = e.mask;
            idle_gap(2 * pp + 8);
            check($sformatf("vec%0d_not_empty", k), not_empty_o, 1);
            do_pop($sformatf("vec%0d_dat", k));
            check($sformatf("vec%0d_drained", k), not_empty_o, 0);
        end

        @(negedge clk_i);
        pop_i = 1'b1;
        @(negedge clk_i);
        pop_i = 1'b0;
        check("pop_empty_hold", dat_o & last_mask, last_exp);

        bits_i = 5'd10;
        baud_i = 32'd8;
        @(negedge clk_i);
        rxd_i = 1'b0;
        @(negedge clk_i);
        rxd_i = 1'b1;
        repeat (40) @(negedge clk_i);
        check("glitch_not_empty", not_empty_o, 0);
        check("glitch_idle", idle_o, 1);

        bits_i = 5'd0;
        baud_i = 32'd4;
        idle_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rxd_i = i[0];
            repeat (3) begin
                @(negedge clk_i);
                idle_ok &= idle_o;
            end
        end
        rxd_i = 1'b1;
        repeat (10) @(negedge clk_i);
        check("disabled_idle", idle_ok, 1);
        check("disabled_not_empty", not_empty_o, 0);

        bits_i = 5'd10;
        baud_i = 32'd4;
        fill(16, 1);
        check("fill16_full", full_o, 1);
        check("fill16_overrun", overrun_o, 0);
        fill(1, 17);
        check("ovr_set", overrun_o, 1);
        check("ovr_full", full_o, 1);
        for (int i = 0; i < 16; i++) do_pop($sformatf("ovr_pop%0d", i));
        check("ovr_drained", not_empty_o, 0);
        @(negedge clk_i);
        clr_ovr_i = 1'b1;
        @(negedge clk_i);
        clr_ovr_i = 1'b0;
        check("ovr_clear", overrun_o, 0);

        fill(16, 32);
        seen = 1'b0;
        fork
            send_bits(16'h200 | 16'(60 << 1), 10, 4);
            begin
                for (int i = 0; i < 100 && !seen; i++) begin
                    @(negedge clk_i);
                    if (dut.state == PUSH) begin
                        pop_i = 1'b1;
                        seen = 1'b1;
                        @(negedge clk_i);
                        pop_i = 1'b0;
                    end
                end
            end
        join
        check("pushpop_seen", seen, 1);
        sb_compare("pushpop_head");
        sb_push(16'h200 | 16'(60 << 1), 10);
        idle_gap(16);
        check("pushpop_no_ovr", overrun_o, 0);
        check("pushpop_full", full_o, 1);
        for (int i = 0; i < 15; i++) do_pop($sformatf("pp_pop%0d", i));
        check("pp_one_left", not_empty_o, 1);
        do_pop("pp_pop15");
        check("pp_drained", not_empty_o, 0);

        fill(1, 90);
        check("pre_rst_not_empty", not_empty_o, 1);
        send_bits(16'h02AA, 5, 4);
        reset_ni = 1'b0;
        #1;
        check("mid_rst_not_empty", not_empty_o, 0);
        check("mid_rst_dat", dat_o, 0);
        check("mid_rst_idle", idle_o, 1);
        check("mid_rst_overrun", overrun_o, 0);
        check("mid_rst_full", full_o, 0);
        sbq.delete();
        rxd_i = 1'b1;
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b1;
        idle_gap(20);
        send_bits(16'h03C6, 10, 4);
        sb_push(16'h03C6, 10);
        idle_gap(16);
        check("post_rst_not_empty", not_empty_o, 1);
        do_pop("post_rst_dat");
        check("post_rst_drained", not_empty_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
